branch_resolve: RTL
===================

BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  resolved-branch operands present.
REQ-005 in_ready  output  1  block can accept this cycle.
REQ-006 funct3  input  3  RV32I branch funct3 (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU).
REQ-007 alu_f  input  32  ALU result (SUB for BEQ/BNE, SLT for BLT/BGE, USLT for BLTU/BGEU).
REQ-008 alu_zero  input  1  ALU zero flag.
REQ-009 pred_taken  input  1  front-end prediction.
REQ-010 pc, imm  input  32 each  branch PC and sign-extended B-immediate.
REQ-011 flush  input  1  kill: suppresses acceptance this cycle.
REQ-012 redirect_valid  output  1  one-cycle mispredict redirect pulse.
REQ-013 redirect_pc  output  32  corrected fetch PC.
REQ-014 upd_valid, upd_ready  output, input  1 each  predictor-update handshake.
REQ-015 upd_pc  output  32  PC of resolved branch; upd_taken  output  1  actual outcome.

Function
REQ-016 Accept (fire) SHALL occur when in_valid && in_ready && !flush.
REQ-017 Taken SHALL be: BEQ alu_zero; BNE !alu_zero; BLT/BLTU alu_f[0]; BGE/BGEU !alu_f[0].
REQ-018 funct3 010/011 SHALL be illegal: accepted, no redirect, no update, not counted.
REQ-019 Target SHALL be pc+imm if taken else pc+4, modulo 2^32 (wrap, no overflow flag).
REQ-020 Mispredict SHALL be taken != pred_taken; on fire at cycle N with mispredict, redirect_valid=1 and redirect_pc=target in cycle N+1 only.
REQ-021 redirect_valid SHALL be 0 in every cycle not directly following a mispredicting fire; redirect_pc holds last value otherwise.
REQ-022 Update buffer SHALL be a single entry with states EMPTY/FULL; FULL drives upd_valid=1.
REQ-023 EMPTY->FULL on legal fire; FULL->EMPTY on upd_ready without fire; FULL->FULL (reloaded with new branch) on upd_ready and legal fire in the same cycle.
REQ-024 in_ready SHALL be !upd_valid || upd_ready (combinational, no dependence on in_valid).
REQ-025 upd_pc/upd_taken SHALL stay stable while upd_valid && !upd_ready.
REQ-026 Redirect SHALL NOT wait for update handshake; an update stall only deasserts in_ready.
REQ-027 flush SHALL NOT discard a FULL buffer or a redirect already registered.

Reset
REQ-028 On reset: buffer EMPTY, upd_valid=0, redirect_valid=0, redirect_pc=0, upd_pc=0, upd_taken=0, counters 0.
REQ-029 Reset SHALL override a simultaneous fire or update handshake; pending update is dropped.

Configuration
REQ-030 Macro BRU_PERF_CNT_EN SHALL, when defined, add outputs branch_cnt and mispred_cnt (32 bits each, free-running, wrap at 2^32).
REQ-031 With BRU_PERF_CNT_EN: branch_cnt +1 per legal fire, mispred_cnt +1 per mispredicting fire, both visible the cycle after fire.
REQ-032 Without BRU_PERF_CNT_EN: ports and counter logic absent; all other behaviour identical.

Verification
REQ-033 BEQ, alu_zero=1, pred_taken=0, pc=0x100, imm=0x40, upd_ready=1 -> next cycle redirect_valid=1, redirect_pc=0x140, upd_valid=1, upd_taken=1.
REQ-034 BLTU, alu_f=0, pred_taken=0, pc=0xFFFFFFFC -> no redirect; upd_pc=0xFFFFFFFC, upd_taken=0; correct target 0x00000000 wraps.
REQ-035 upd_ready=0 held 3 cycles after a fire -> in_ready=0, upd_* stable; release with in_valid=1 -> handshake and reload same cycle, upd_valid stays 1.
REQ-036 funct3=010 with in_valid=1 -> accepted, redirect_valid=0, upd_valid=0, counters unchanged.
REQ-037 flush=1 with mispredicting input -> no redirect, no update; reset asserted while buffer FULL -> upd_valid=0 next cycle.
REQ-038 With BRU_PERF_CNT_EN: 5 legal branches, 2 mispredicted -> branch_cnt=5, mispred_cnt=2; preload 0xFFFFFFFF +1 -> 0.

Source files
------------

// File: rtl/branch_resolve.sv
// Branch resolution: evaluates RV32I branch outcome, issues a one-cycle mispredict
// redirect and holds a single-entry predictor update. Optional perf counters: BRU_PERF_CNT_EN.
module branch_resolve (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_f,
  input  logic        alu_zero,
  input  logic        pred_taken,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        upd_valid,
  input  logic        upd_ready,
  output logic [31:0] upd_pc,
  output logic        upd_taken
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
`endif
);

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_funct3_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_e;

  buf_state_e  state_q, state_d;
  logic        fire;
  logic        legal;
  logic        taken;
  logic        mispredict;
  logic        load;
  logic [31:0] target;

  // Only bit 0 of the compare result carries the SLT/USLT answer; equality
  // comes in through alu_zero, so the upper bits are intentionally ignored.
  logic        unused_alu_bits;
  assign unused_alu_bits = ^alu_f[31:1];

  // Outcome decode
  always_comb begin
    // NOTE: default every comb output first so no path leaves it unassigned (no latch).
    legal = 1'b1;
    taken = 1'b0;
    case (br_funct3_e'(funct3))
      F3_BEQ:  taken = alu_zero;
      F3_BNE:  taken = ~alu_zero;
      F3_BLT:  taken = alu_f[0];
      F3_BGE:  taken = ~alu_f[0];
      F3_BLTU: taken = alu_f[0];
      F3_BGEU: taken = ~alu_f[0];
      default: legal = 1'b0;
    endcase
  end

  assign in_ready   = ~upd_valid | upd_ready;
  assign fire       = in_valid & in_ready & ~flush;
  assign load       = fire & legal;
  assign mispredict = taken ^ pred_taken;
  assign target     = taken ? (pc + imm) : (pc + 32'd4);

  // Update buffer FSM: state register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Update buffer FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (load) state_d = FULL;
      FULL: begin
        if (load)           state_d = FULL;
        else if (upd_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Update buffer FSM: outputs
  always_comb begin
    upd_valid = (state_q == FULL);
  end

  // Payload only moves on a legal fire, which keeps it stable during a stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      upd_pc    <= 32'd0;
      upd_taken <= 1'b0;
    end else if (load) begin
      upd_pc    <= pc;
      upd_taken <= taken;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
    end else begin
      redirect_valid <= load & mispredict;
      if (load && mispredict) redirect_pc <= target;
    end
  end

`ifdef BRU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_cnt  <= 32'd0;
      mispred_cnt <= 32'd0;
    end else if (load) begin
      branch_cnt <= branch_cnt + 32'd1;
      if (mispredict) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end
`endif

endmodule
